// File: rtl/pipe_chain.sv
// pipe_chain: in-order register chain with valid/ready at both ends,
// per-stage stall and flush, bubble collapsing and exported stage state.
module pipe_chain #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic [DEPTH-1:0]         stall,
  input  logic [DEPTH-1:0]         flush,
  output logic [DEPTH-1:0]         stage_valid,
  output logic [DEPTH*WIDTH-1:0]   stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] adv;
  logic [DEPTH:0]   rdy;
  logic             in_fire;
  logic             out_fire;

  // Ready chain walks from the consumer back to stage 0; a flushed stage counts as empty.
  always_comb begin
    ev  = '0;
    adv = '0;
    rdy = '0;
    rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      ev[i]  = valid_q[i] & ~flush[i];
      adv[i] = ev[i] & ~stall[i] & rdy[i+1];
      rdy[i] = ~ev[i] | adv[i];
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = ev[DEPTH-1] & ~stall[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state: a stage loads from behind, else empties when it advances or is flushed.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_fire) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
    end else if (adv[0] | flush[0]) begin
      valid_d[0] = 1'b0;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
      end else if (adv[i] | flush[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire)
          - OCC_W'($countones(valid_q & flush));
  end

  // State registers; reset clears every stage including its payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Flatten stage payloads for hazard/forwarding readers.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      stage_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign stage_valid = valid_q;
  assign out_data    = data_q[DEPTH-1];
  assign occupancy   = occ_q;

  occ_matches_valid : assert property (@(posedge clk) disable iff (rst)
    occ_q == OCC_W'($countones(valid_q)));

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: accepted payloads queue up as expected
// outputs, the monitor pops them on every delivery.
module tb_pipe_chain;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [63:0] d;
    int          c;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [2:0]             occupancy;

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   max_occ = 0;
  bit   chk_lat = 1'b0;
  ent_t exp_q[$];
  logic [63:0] kill_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor/scoreboard: state checks, deliveries, squashes, then acceptances.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      exp_q.delete();
      kill_q.delete();
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end else begin
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL out_unexpected: got %h expected no delivery (cycle %0d)", out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          if (chk_lat) check("latency", 64'(cyc - e.c), 64'(DEPTH));
        end
      end
      if (flush != '0) begin
        foreach (kill_q[k]) begin
          for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].d == kill_q[k]) begin
              exp_q.delete(j);
              break;
            end
          end
        end
        kill_q.delete();
      end
      if (in_valid && in_ready) exp_q.push_back('{in_data, cyc});
    end
  end

  // Present one payload until accepted; reports how many cycles it waited.
  task automatic send(input logic [63:0] v, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    stall     = '0;
    flush     = '0;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || occupancy != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_occ", 64'(occupancy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall = '0; flush = '0;
    #1;
    check("reset_stage_valid", 64'(stage_valid), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    #21;
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Streaming: back-to-back, latency DEPTH, in_ready never drops.
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    max_occ   = 0;
    for (int v = 'h10; v <= 'h17; v++) begin
      send(64'(v), w);
      check("stream_no_wait", 64'(w), 64'd0);
    end
    drain();
    chk_lat = 1'b0;
    check("stream_peak_occ", 64'(max_occ), 64'd4);

    // Backpressure: fill, hold, then 1-in/1-out.
    out_ready = 1'b0;
    for (int v = 'h20; v < 'h24; v++) send(64'(v), w);
    in_valid = 1'b1;
    in_data  = 64'h24;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_occ_full", 64'(occupancy), 64'd4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rises", 64'(in_ready), 64'd1);
    for (int v = 'h24; v < 'h2a; v++) begin
      send(64'(v), w);
      check("bp_stream_no_wait", 64'(w), 64'd0);
    end
    drain();

    // Stall with bubble collapse: A at stage 3, B at stage 1.
    out_ready = 1'b0;
    send(64'hA, w);
    @(posedge clk); #1;
    send(64'hB, w);
    @(posedge clk); #1;
    check("stall_setup_valid", 64'(stage_valid), 64'b1010);
    stall = 4'b1000;
    out_ready = 1'b1;
    #1;
    check("stall_out_valid", 64'(out_valid), 64'd0);
    check("stall_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("stall_collapse_valid", 64'(stage_valid), 64'b1100);
    check("stall_b_stage2", stage_data[2*WIDTH +: WIDTH], 64'hB);
    check("stall_a_out_data", out_data, 64'hA);
    check("stall_out_valid2", 64'(out_valid), 64'd0);
    check("stall_in_ready2", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("stall_hold_valid", 64'(stage_valid), 64'b1100);
    drain();

    // Flush squash: stages 0..3 hold 1,2,3,4; flush 0..1 while 5 enters.
    out_ready = 1'b0;
    for (int v = 4; v >= 1; v--) send(64'(v), w);
    flush = 4'b0011;
    kill_q.push_back(64'd1);
    kill_q.push_back(64'd2);
    send(64'd5, w);
    check("flush_no_wait", 64'(w), 64'd0);
    flush = '0;
    check("flush_stage_valid", 64'(stage_valid), 64'b1101);
    check("flush_stage0", stage_data[0 +: WIDTH], 64'd5);
    check("flush_occ", 64'(occupancy), 64'd3);
    drain();

    // Flush beats stall on stage 2; stage 1 moves in at the same edge.
    out_ready = 1'b0;
    for (int v = 'h31; v <= 'h34; v++) send(64'(v), w);
    stall = 4'b0100;
    flush = 4'b0100;
    kill_q.push_back(64'h32);
    @(posedge clk); #1;
    stall = '0;
    flush = '0;
    check("fbs_stage_valid", 64'(stage_valid), 64'b1110);
    check("fbs_stage2", stage_data[2*WIDTH +: WIDTH], 64'h33);
    check("fbs_stage1", stage_data[1*WIDTH +: WIDTH], 64'h34);
    check("fbs_occ", 64'(occupancy), 64'd3);
    drain();

    // Randomized traffic with stalls; ordering and occupancy tracked by the scoreboard.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      @(posedge clk); #1;
    end
    drain();

    // Reset between edges with 3 entries held.
    out_ready = 1'b0;
    for (int v = 'h41; v <= 'h43; v++) send(64'(v), w);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_stage_valid", 64'(stage_valid), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("post_rst_stage_valid", 64'(stage_valid), 64'd0);
    chk_lat = 1'b1;
    for (int v = 'h50; v < 'h53; v++) send(64'(v), w);
    drain();
    chk_lat = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised in-order pipeline register chain that replaces hand-instantiated inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB style) with one block. It adds a valid/ready handshake at both ends, a per-stage stall, a per-stage flush and bubble collapsing. Every stage's contents and valid bit are exported so hazard and forwarding logic can read them. It sits between the fetch front end and writeback, or anywhere a multi-cycle datapath needs ordered, killable buffering.

## Interface
- WIDTH, 64: payload bits per stage.
- DEPTH, 4: number of register stages. Stage 0 is the youngest; stage DEPTH-1 is the oldest and drives the output. DEPTH must be at least 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer holds a valid payload.
- in_ready  out  1  stage 0 can accept a payload this cycle.
- in_data  in  WIDTH  payload.
- out_valid  out  1  stage DEPTH-1 is presenting a deliverable payload.
- out_ready  in  1  consumer accepts the payload.
- out_data  out  WIDTH  stage DEPTH-1 payload.
- stall  in  DEPTH  bit i set: stage i must not pass its entry forward this cycle.
- flush  in  DEPTH  bit i set: the entry held in stage i is discarded at the next edge.
- stage_valid  out  DEPTH  registered valid bit of each stage.
- stage_data  out  DEPTH*WIDTH  registered payload of each stage; stage i occupies bits [i*WIDTH +: WIDTH].
- occupancy  out  clog2(DEPTH+1)  registered count of valid stages.

## Operation
- Per stage i, with ready_DEPTH = out_ready:
  - ev_i = valid_i & ~flush_i.
  - adv_i = ev_i & ~stall_i & ready_(i+1).
  - ready_i = ~ev_i | adv_i.
  - The ready chain is combinational from out_ready to in_ready. There is no skid buffer.
- in_ready = ready_0 & ~rst. out_valid = adv_(DEPTH-1) qualified by out_ready removed, i.e. out_valid = ev_(DEPTH-1) & ~stall_(DEPTH-1). out_data = data_(DEPTH-1).
- Input fire occurs when in_valid & in_ready. Output fire occurs when out_valid & out_ready.
- Update of stage i at the edge, for i > 0 (stage 0 uses the input fire as its source):
  - If adv_(i-1): load data_(i-1); valid_i becomes 1.
  - Else if adv_i or flush_i: valid_i becomes 0; data is held, and its value is don't-care.
  - Else: hold.
- Bubbles collapse. An empty stage, or one being flushed, accepts from the stage behind it even when its own stall bit is set. Stall on an empty stage has no effect.
- Flush and stall on the same stage: flush wins. The entry is dropped and the stage is ready.
- A flush never kills an entry that is moving into the flushed stage in the same cycle; it kills only the resident entry. Flushing stages 0..k therefore squashes everything younger than stage k+1, which is the branch-mispredict use.
- A flushed entry is never delivered on out_*.
- Ordering is strictly preserved. Entries are never duplicated or reordered.
- occupancy_next = occupancy + in_fire − out_fire − popcount(valid & flush). The block must always satisfy occupancy == popcount(stage_valid); an SVA assertion checks this.

## Timing
- Reset (asynchronous) sets every stage_valid to 0, every stage_data to 0, and occupancy to 0. Consequently out_valid = 0, out_data = 0 and in_ready = 0 while rst is high.
- in_ready rises combinationally in the first cycle after rst deasserts.
- Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.
- Latency: a payload accepted at edge n, with no stalls and out_ready held high, is in stage 0 after edge n. out_valid is high in the cycle following edge n+DEPTH−1, giving DEPTH cycles acceptance-to-presentation.
- Throughput is 1 payload per cycle, including when full (DEPTH entries) with out_ready high: a simultaneous in_fire and out_fire is legal.
- Full pipe with out_ready low: in_ready = 0. It rises in the same cycle that out_ready rises.
- All outputs except in_ready and out_valid are registered. in_ready depends combinationally on out_ready, stall and flush; out_valid depends combinationally on stall and flush.

## Test plan
- Streaming, DEPTH=4, WIDTH=64:
  - Stimulus: feed 0x10..0x17 back-to-back, out_ready=1.
  - Required: first output in the 4th cycle after the first accept, then one payload per cycle; occupancy peaks at 4; in_ready never drops.
- Backpressure:
  - Stimulus: fill 4 entries with out_ready=0, then raise out_ready and keep in_valid high.
  - Required: in_ready=0 and occupancy=4 while held; afterwards 1 payload in and 1 out per cycle, order preserved.
- Stall with bubble collapse:
  - Stimulus: entries A,B in stages 3,1; stall[3]=1 for 2 cycles.
  - Required: B advances to stage 2 and stops; A remains on out_data with out_valid=0; in_ready stays 1 while stage 0 or 1 is free.
- Flush squash:
  - Stimulus: stages 0..3 hold 1,2,3,4; assert flush=4'b0011 for one cycle with in_valid carrying 5.
  - Required: next cycle stage_valid=4'b1101 with stage 0 = 5; occupancy=3; outputs delivered in the order 4,3,5; 1 and 2 are never delivered.
- Flush beats stall:
  - Stimulus: stall[2]=flush[2]=1 with stage 1 valid.
  - Required: the stage 2 entry is dropped; the stage 1 entry moves into stage 2 at the same edge.
- Reset mid-operation:
  - Stimulus: assert rst between edges with 3 entries held.
  - Required: stage_valid=0, occupancy=0, out_valid=0 and in_ready=0 immediately; no stale payload ever appears after release.
